// File: rtl/wb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_pkg                                                               |
// | Shared types and widths for the writeback arbiter slice.             |
// |   XLEN     : register data width                                     |
// |   REG_AW   : register-file address width                             |
// |   wb_req_t : one pending register write {rd, data}                   |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package wb_pkg;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   data;
   } wb_req_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_fifo                                                            |
// | Single-clock FIFO with wrap-around pointers and an occupancy count.  |
// | A push while full and a pop while empty are ignored. Push and pop    |
// | in the same cycle both take effect. The head is shown combinationally|
// | from storage; there is no bypass from the write side.                |
// |   clk_i, rst_i : clock, synchronous active-high reset                |
// |   push_i       : write wdata_i if not full                           |
// |   wdata_i      : element to write                                    |
// |   pop_i        : drop the head if not empty                          |
// |   rdata_o      : current head element                                |
// |   full_o       : no free entries                                     |
// |   empty_o      : no valid entries                                    |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module sync_fifo
   import wb_pkg::*;
#(
   parameter int  DEPTH = 4,
   parameter type T     = wb_req_t
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic push_i,
   input  T     wdata_i,
   input  logic pop_i,
   output T     rdata_o,
   output logic full_o,
   output logic empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q,  count_d;
   T              mem_q [DEPTH];

   logic do_push;
   logic do_pop;

   assign full_o  = (count_q == C_FULL);
   assign empty_o = (count_q == '0);
   assign rdata_o = mem_q[rd_ptr_q];

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset: an entry is only ever read after being written.
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

endmodule
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_arbiter                                                           |
// | Owns the register file write port. Single-cycle ALU results have     |
// | priority; FPU results queue in a FIFO. A wait counter stalls the ALU |
// | once the FIFO head has been bypassed MAX_WAIT times.                 |
// |   clk_i, rst_i        : clock, synchronous active-high reset         |
// |   alu_valid_i/rd/data : ALU result this cycle                        |
// |   alu_stall_o         : ALU slot denied, upstream holds its result   |
// |   fpu_valid_i/rd/data : FPU result offer                             |
// |   fpu_ready_o         : FIFO has room (transfer on valid && ready)   |
// |   rd_addr_o/data/wren : registered regfile write port                |
// |   fpu_pending_o       : FIFO non-empty, for hazard detection         |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module wb_arbiter
   import wb_pkg::*;
#(
   parameter int DEPTH    = 4,
   parameter int MAX_WAIT = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              alu_valid_i,
   input  logic [REG_AW-1:0] alu_rd_i,
   input  logic [XLEN-1:0]   alu_data_i,
   output logic              alu_stall_o,
   input  logic              fpu_valid_i,
   output logic              fpu_ready_o,
   input  logic [REG_AW-1:0] fpu_rd_i,
   input  logic [XLEN-1:0]   fpu_data_i,
   output logic [REG_AW-1:0] rd_addr_o,
   output logic [XLEN-1:0]   rd_data_o,
   output logic              rd_wren_o,
   output logic              fpu_pending_o
);

   localparam int WW = $clog2(MAX_WAIT + 1);
   localparam logic [WW-1:0] C_MAX_WAIT = WW'(MAX_WAIT);

   logic [WW-1:0]     wait_cnt_q, wait_cnt_d;
   logic              rd_wren_q,  rd_wren_d;
   logic [REG_AW-1:0] rd_addr_q,  rd_addr_d;
   logic [XLEN-1:0]   rd_data_q,  rd_data_d;

   wb_req_t fifo_wdata;
   wb_req_t fifo_head;
   logic    fifo_push;
   logic    fifo_pop;
   logic    fifo_full;
   logic    fifo_empty;
   logic    grant_alu;

   assign fifo_wdata = '{rd: fpu_rd_i, data: fpu_data_i};

   sync_fifo #(
      .DEPTH (DEPTH),
      .T     (wb_req_t)
   ) u_fpu_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (fifo_push),
      .wdata_i (fifo_wdata),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Stall is a pure decode of the counter, so it never depends on
   // same-cycle inputs and upstream can use it without a timing loop.
   assign alu_stall_o   = (wait_cnt_q == C_MAX_WAIT);
   assign fpu_ready_o   = !fifo_full;
   assign fpu_pending_o = !fifo_empty;

   assign grant_alu = alu_valid_i && !alu_stall_o;
   assign fifo_pop  = !grant_alu && !fifo_empty;
   assign fifo_push = fpu_valid_i && !fifo_full;

   always_comb begin
      rd_wren_d = 1'b0;
      rd_addr_d = rd_addr_q;
      rd_data_d = rd_data_q;
      if (grant_alu) begin
         rd_addr_d = alu_rd_i;
         rd_data_d = alu_data_i;
         rd_wren_d = (alu_rd_i != '0);
      end else if (fifo_pop) begin
         // x0 writes still consume the slot and the FIFO entry.
         rd_addr_d = fifo_head.rd;
         rd_data_d = fifo_head.data;
         rd_wren_d = (fifo_head.rd != '0);
      end
   end

   // The counter measures how long the current head has been bypassed;
   // with a non-empty FIFO and no pop, the ALU must have taken the slot.
   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (fifo_empty || fifo_pop) begin
         wait_cnt_d = '0;
      end else if (grant_alu && (wait_cnt_q != C_MAX_WAIT)) begin
         wait_cnt_d = wait_cnt_q + WW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wait_cnt_q <= '0;
         rd_wren_q  <= 1'b0;
         rd_addr_q  <= '0;
         rd_data_q  <= '0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
         rd_wren_q  <= rd_wren_d;
         rd_addr_q  <= rd_addr_d;
         rd_data_q  <= rd_data_d;
      end
   end

   assign rd_wren_o = rd_wren_q;
   assign rd_addr_o = rd_addr_q;
   assign rd_data_o = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_wb_arbiter                                                        |
// | Self-checking bench: directed scenarios with literal expectations,   |
// | then randomized traffic compared every cycle against a queue-based   |
// | reference model of the writeback rules.                              |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_wb_arbiter;
   import wb_pkg::*;

   localparam int DEPTH    = 4;
   localparam int MAX_WAIT = 4;

   logic              clk;
   logic              rst;
   logic              alu_valid;
   logic [REG_AW-1:0] alu_rd;
   logic [XLEN-1:0]   alu_data;
   logic              alu_stall_o;
   logic              fpu_valid;
   logic              fpu_ready_o;
   logic [REG_AW-1:0] fpu_rd;
   logic [XLEN-1:0]   fpu_data;
   logic [REG_AW-1:0] rd_addr_o;
   logic [XLEN-1:0]   rd_data_o;
   logic              rd_wren_o;
   logic              fpu_pending_o;

   int n_cmp = 0;
   int n_bad = 0;

   wb_arbiter #(
      .DEPTH    (DEPTH),
      .MAX_WAIT (MAX_WAIT)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .alu_valid_i   (alu_valid),
      .alu_rd_i      (alu_rd),
      .alu_data_i    (alu_data),
      .alu_stall_o   (alu_stall_o),
      .fpu_valid_i   (fpu_valid),
      .fpu_ready_o   (fpu_ready_o),
      .fpu_rd_i      (fpu_rd),
      .fpu_data_i    (fpu_data),
      .rd_addr_o     (rd_addr_o),
      .rd_data_o     (rd_data_o),
      .rd_wren_o     (rd_wren_o),
      .fpu_pending_o (fpu_pending_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Queue of buffered FPU results, number of times the current head has
   // been passed over by the ALU, and the write last presented to the regfile.
   wb_req_t           m_q[$];
   int                m_skips = 0;
   bit                m_wren  = 0;
   logic [REG_AW-1:0] m_addr  = '0;
   logic [XLEN-1:0]   m_data  = '0;
   bit                m_live  = 0;
   int                m_n;
   wb_req_t           m_h;

   always @(posedge clk) begin
      if (rst) begin
         m_q.delete();
         m_skips = 0;
         m_wren  = 0;
         m_addr  = '0;
         m_data  = '0;
         m_live  = 1;
      end else begin
         m_n = m_q.size();
         if (alu_valid && (m_skips < MAX_WAIT)) begin
            m_wren = (alu_rd != 0);
            m_addr = alu_rd;
            m_data = alu_data;
            m_skips = (m_n > 0) ? m_skips + 1 : 0;
         end else if (m_n > 0) begin
            m_h     = m_q.pop_front();
            m_wren  = (m_h.rd != 0);
            m_addr  = m_h.rd;
            m_data  = m_h.data;
            m_skips = 0;
         end else begin
            m_wren  = 0;
            m_skips = 0;
         end
         if (fpu_valid && (m_n < DEPTH)) begin
            m_q.push_back('{rd: fpu_rd, data: fpu_data});
         end
      end
   end

   always @(negedge clk) begin
      if (m_live) begin
         check("stall",   32'(alu_stall_o),   32'(m_skips == MAX_WAIT));
         check("ready",   32'(fpu_ready_o),   32'(m_q.size() < DEPTH));
         check("pending", 32'(fpu_pending_o), 32'(m_q.size() != 0));
         check("wren",    32'(rd_wren_o),     32'(m_wren));
         if (m_wren) begin
            check("addr", 32'(rd_addr_o), 32'(m_addr));
            check("data", rd_data_o, m_data);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      alu_valid = 1'b0;
      alu_rd    = '0;
      alu_data  = '0;
      fpu_valid = 1'b0;
      fpu_rd    = '0;
      fpu_data  = '0;
   endtask

   logic cur_stall;
   logic cur_ready;
   int   alu_pct;

   initial begin
      idle_inputs();
      rst = 1'b1;
      repeat (2) tick();
      check("rst_wren",    32'(rd_wren_o),     32'd0);
      check("rst_addr",    32'(rd_addr_o),     32'd0);
      check("rst_data",    rd_data_o,          32'd0);
      check("rst_stall",   32'(alu_stall_o),   32'd0);
      check("rst_pending", 32'(fpu_pending_o), 32'd0);
      check("rst_ready",   32'(fpu_ready_o),   32'd1);
      rst = 1'b0;

      // ALU only
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h0000_002A;
      tick();
      check("alu_wren", 32'(rd_wren_o), 32'd1);
      check("alu_addr", 32'(rd_addr_o), 32'd5);
      check("alu_data", rd_data_o,      32'h2A);
      alu_valid = 1'b0;
      tick();
      check("alu_idle", 32'(rd_wren_o), 32'd0);

      // FPU only
      fpu_valid = 1'b1; fpu_rd = 5'd3; fpu_data = 32'h3F80_0000;
      tick();
      fpu_valid = 1'b0;
      check("fpu_pend_c1", 32'(fpu_pending_o), 32'd1);
      check("fpu_wren_c1", 32'(rd_wren_o),     32'd0);
      tick();
      check("fpu_wren_c2", 32'(rd_wren_o),     32'd1);
      check("fpu_addr_c2", 32'(rd_addr_o),     32'd3);
      check("fpu_data_c2", rd_data_o,          32'h3F80_0000);
      check("fpu_pend_c2", 32'(fpu_pending_o), 32'd0);
      tick();

      // FIFO full with the ALU busy every cycle
      alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
      for (int i = 0; i < 4; i++) begin
         fpu_valid = 1'b1; fpu_rd = 5'(10 + i); fpu_data = 32'(32'h100 + i);
         tick();
      end
      check("full_ready_c4", 32'(fpu_ready_o), 32'd0);
      fpu_rd = 5'd14; fpu_data = 32'h104;
      tick();
      check("full_stall_c5", 32'(alu_stall_o), 32'd1);
      check("full_ready_c5", 32'(fpu_ready_o), 32'd0);
      tick();
      check("full_ready_c6", 32'(fpu_ready_o), 32'd1);
      check("full_wren_c6",  32'(rd_wren_o),   32'd1);
      check("full_addr_c6",  32'(rd_addr_o),   32'd10);
      check("full_data_c6",  rd_data_o,        32'h100);
      tick();
      fpu_valid = 1'b0; alu_valid = 1'b0;
      check("full_ready_c7", 32'(fpu_ready_o), 32'd0);
      repeat (6) tick();
      check("full_drained", 32'(fpu_pending_o), 32'd0);

      // Starvation guard
      alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h11;
      fpu_valid = 1'b1; fpu_rd = 5'd9; fpu_data = 32'h99;
      tick();
      fpu_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check("starve_nostall", 32'(alu_stall_o), 32'd0);
         tick();
      end
      check("starve_stall", 32'(alu_stall_o), 32'd1);
      tick();
      check("starve_fwren", 32'(rd_wren_o),   32'd1);
      check("starve_faddr", 32'(rd_addr_o),   32'd9);
      check("starve_fdata", rd_data_o,        32'h99);
      check("starve_clear", 32'(alu_stall_o), 32'd0);
      tick();
      check("starve_awren", 32'(rd_wren_o), 32'd1);
      check("starve_aaddr", 32'(rd_addr_o), 32'd1);
      alu_valid = 1'b0;
      tick();

      // x0 suppression
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEAD;
      fpu_valid = 1'b1; fpu_rd = 5'd0; fpu_data = 32'hBEEF;
      tick();
      idle_inputs();
      check("x0_wren_c1", 32'(rd_wren_o),     32'd0);
      check("x0_pend_c1", 32'(fpu_pending_o), 32'd1);
      tick();
      check("x0_wren_c2", 32'(rd_wren_o),     32'd0);
      check("x0_pend_c2", 32'(fpu_pending_o), 32'd0);
      tick();
      check("x0_wren_c3", 32'(rd_wren_o), 32'd0);

      // Reset mid-run with three queued entries
      alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h22;
      for (int i = 0; i < 3; i++) begin
         fpu_valid = 1'b1; fpu_rd = 5'(20 + i); fpu_data = 32'(32'h200 + i);
         tick();
      end
      idle_inputs();
      check("mid_pend_pre", 32'(fpu_pending_o), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_pend",  32'(fpu_pending_o), 32'd0);
      check("mid_ready", 32'(fpu_ready_o),   32'd1);
      check("mid_stall", 32'(alu_stall_o),   32'd0);
      check("mid_wren",  32'(rd_wren_o),     32'd0);
      for (int k = 0; k < 5; k++) begin
         tick();
         check("mid_nostale", 32'(rd_wren_o), 32'd0);
      end

      // Randomized traffic; upstream holds an offer until it is taken
      cur_stall = 1'b0;
      cur_ready = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         alu_pct = (c < 1000) ? 90 : ((c < 2000) ? 50 : 20);
         if (!(alu_valid && cur_stall && !rst)) begin
            alu_valid = ($urandom_range(0, 99) < alu_pct);
            alu_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            alu_data  = $urandom;
         end
         if (!(fpu_valid && !cur_ready && !rst)) begin
            fpu_valid = ($urandom_range(0, 99) < 60);
            fpu_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            fpu_data  = $urandom;
         end
         rst       = ($urandom_range(0, 599) == 0);
         cur_stall = alu_stall_o;
         cur_ready = fpu_ready_o;
         tick();
      end
      rst = 1'b0;
      idle_inputs();
      repeat (20) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter that owns the register file's single write port. It merges single-cycle integer ALU results with variable-latency FPU results and drives the regfile's `rd_addr_i`/`rd_data_i`/`rd_wren_i` from registered outputs. FPU results are buffered in a small FIFO. The ALU has priority, and a wait counter stalls the ALU once the FPU has waited too long, so the FPU cannot starve.

## Interface
- `DEPTH`, default 4: FPU result FIFO entries (power of two, ≥2).
- `MAX_WAIT`, default 8: cycles a non-empty FIFO head may be blocked before the ALU is stalled (≥1).
- `clk_i` in 1: the only clock.
- `rst_i` in 1: reset, synchronous and active-high.
- `alu_valid_i` in 1: ALU result present this cycle.
- `alu_rd_i` in 5: ALU destination register.
- `alu_data_i` in 32: ALU result.
- `alu_stall_o` out 1: ALU slot denied this cycle; upstream holds its result stable.
- `fpu_valid_i` in 1: FPU result offered.
- `fpu_ready_o` out 1: FIFO can accept; transfer when valid && ready.
- `fpu_rd_i` in 5: FPU destination register.
- `fpu_data_i` in 32: FPU result (raw IEEE-754 single bits).
- `rd_addr_o` out 5: to regfile `rd_addr_i`.
- `rd_data_o` out 32: to regfile `rd_data_i`.
- `rd_wren_o` out 1: to regfile `rd_wren_i`.
- `fpu_pending_o` out 1: FIFO non-empty (for hazard detection).

## Operation
- Each cycle, grant at most one source.
  - If `alu_stall_o`=0 and `alu_valid_i`=1: grant the ALU.
  - Otherwise, if the FIFO is non-empty: pop the head and grant the FPU.
  - Otherwise: idle.
- `alu_stall_o` = (`wait_cnt` == `MAX_WAIT`). It is decoded from a register and does not depend on any input in the same cycle.
- `wait_cnt` (width `$clog2(MAX_WAIT+1)`):
  - Clears to 0 when the FIFO is empty or when a pop occurs.
  - Otherwise increments by 1 when the FIFO is non-empty and the ALU takes the slot.
  - Saturates at `MAX_WAIT`.
- While `alu_stall_o`=1, the FIFO is guaranteed non-empty, so the FPU head is popped. `wait_cnt` then returns to 0 next cycle.
- `fpu_ready_o` = !full, from the registered count. There is no same-cycle bypass from pop to push.
- Push and pop in the same cycle: both occur and the count is unchanged. This is legal at any occupancy below full.
- A granted result with rd == 0 drives `rd_wren_o`=0. For the FPU, the slot and the pop are still consumed.
- `alu_valid_i` asserted while `alu_stall_o`=1: not accepted. Upstream re-presents it the next cycle.
- The FIFO preserves FPU order. ALU and FPU writes may complete out of program order; the hazard unit uses `fpu_pending_o` to handle this.

## Timing
- Reset values:
  - `rd_wren_o`=0, `rd_addr_o`=0, `rd_data_o`=0.
  - `alu_stall_o`=0, `fpu_pending_o`=0, `fpu_ready_o`=1.
  - FIFO empty, `wait_cnt`=0.
- `rst_i` asserted mid-operation: flushes all FIFO contents and clears `wait_cnt`. No write is issued in the cycle after reset.
- ALU path: `alu_valid_i` in cycle c → `rd_wren_o` high in cycle c+1. The regfile commits at the end of c+1.
- FPU path: accepted in cycle c → eligible at the FIFO head in c+1 → `rd_wren_o` high no earlier than c+2.
- `rd_addr_o`/`rd_data_o` are valid only while `rd_wren_o`=1. When idle they hold their previous values.

## Structure
- Package `wb_pkg`:
  - `wb_req_t` packed struct {`logic [4:0] rd`; `logic [31:0] data`}.
  - Constants `XLEN`=32 and `REG_AW`=5.
- Sub-module `sync_fifo` (parameters `DEPTH` and element type `wb_req_t`):
  - Synchronous reset, full/empty flags, wrap-around read/write pointers plus a count.
- `wb_arbiter` holds the grant logic, `wait_cnt`, and the output registers.

## Test plan
- ALU only: `alu_valid_i`=1, rd=5, data=0x0000_002A in cycle 0 → cycle 1 has `rd_wren_o`=1, `rd_addr_o`=5, `rd_data_o`=0x2A.
- FPU only: push rd=3, data=0x3F80_0000 in cycle 0 → `rd_wren_o`=1 with rd=3 and that data in cycle 2. `fpu_pending_o` is high in cycle 1 and low in cycle 2.
- FIFO full: with `DEPTH`=4 and the ALU valid every cycle, push 4 FPU results → `fpu_ready_o`=0 after the 4th push, and a 5th offer is not accepted until a pop occurs.
- Starvation: `MAX_WAIT`=4, ALU valid every cycle, one FPU entry queued → `alu_stall_o`=1 exactly 4 cycles after the entry reaches the head. The FPU write appears the next cycle, and the ALU resumes one cycle after that.
- x0 suppression: ALU rd=0, then FPU rd=0 → `rd_wren_o` stays 0 throughout, and the FIFO drains to empty.
- Reset mid-run: 3 FPU entries queued and `wait_cnt`=2, assert `rst_i` for 1 cycle → `fpu_pending_o`=0, `fpu_ready_o`=1, and no stale write ever appears.
